mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-master memory arbiter. It lets several bus masters share the single memory port of `memory`: the CPU, reprogrammer, a future DMA engine and the debug UART. It accepts read/write requests on the existing `mem_read`/`mem_write`/`ok` handshake, picks one master per transaction by round-robin, and forwards the registered request to the slave port. The response is returned to the winning master only.

## Interface
Parameters:
- `NUM_MASTERS`, 3: number of master ports; legal range 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `GID_W`, `$clog2(NUM_MASTERS)`: width of the grant index (derived; not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `m_addr`  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- `m_wdata`  in  NUM_MASTERS*DATA_W  per-master write data.
- `m_width`  in  NUM_MASTERS*2  per-master access width (0 byte, 1 half, 2 word).
- `m_read`  in  NUM_MASTERS  per-master read request.
- `m_write`  in  NUM_MASTERS  per-master write request.
- `m_rdata`  out  DATA_W  read data, shared by all masters; valid only while that master's `m_ok` bit is high.
- `m_ok`  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
- `s_addr`  out  ADDR_W  slave address.
- `s_wdata`  out  DATA_W  slave write data.
- `s_width`  out  2  slave access width.
- `s_read`  out  1  slave read strobe.
- `s_write`  out  1  slave write strobe.
- `s_rdata`  in  DATA_W  slave read data; sampled when `s_ok` is high.
- `s_ok`  in  1  slave completion.
- `grant_id`  out  GID_W  index of the current or last granted master.
- `busy`  out  1  high in REQ and RESP.

## Operation
- Master i is requesting when `req[i] = m_read[i] | m_write[i]`. If both are high, the access is a write.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if any `req` is high, choose a winner, latch its addr/wdata/width/direction into the slave registers, set `grant_id`, and go to REQ. Otherwise stay in IDLE.
  - REQ: `s_read` or `s_write` is held high together with the latched fields. On `s_ok=1`, capture `s_rdata` into `m_rdata`, drop the strobes, and go to RESP.
  - RESP: `m_ok[grant_id]=1` for exactly this cycle. No arbitration happens here. Go to IDLE.
- Round-robin: a pointer `last` holds the previous winner. The search starts at `last+1` mod NUM_MASTERS and takes the first requesting master. `last` updates when the arbiter leaves IDLE.
- Slave fields are registered at grant time. Master changes or request withdrawal during REQ/RESP are ignored. The transaction completes and `ok` still pulses.
- A master must deassert its request by the clock edge that ends its `m_ok` cycle. A request still high in the following IDLE is treated as a new transaction.
- `m_rdata` is updated only on the `s_ok` of a read. Writes leave it unchanged.
- Reset values:
  - State is IDLE.
  - `m_ok=0`, `m_rdata=0`.
  - `s_read=s_write=0`, `s_addr=s_wdata=0`, `s_width=0`.
  - `grant_id=0`, `busy=0`.
  - `last=NUM_MASTERS-1`, so master 0 wins first after reset.
- Reset asserted in REQ or RESP: the transaction is aborted, no `m_ok` is issued, and all outputs return to reset values on the next edge.

## Timing
- Request sampled high in IDLE at edge k produces: slave strobe high from cycle k+1; `s_ok` accepted from cycle k+1 onward (a combinational slave may answer in the same cycle); `m_ok` in the cycle after `s_ok` was sampled.
- Minimum transaction is 3 cycles (IDLE, REQ, RESP). Peak throughput is 1 access per 3 cycles.
- Slave strobes stay high for every REQ cycle until `s_ok`. There is no timeout.
- `m_ok` is never high for two consecutive cycles and never has more than one bit set.

## Configuration
- `ARB_FIXED_PRIO_EN`
  - Defined: master 0 has absolute priority. In IDLE, if `req[0]` is high, master 0 wins regardless of `last`. The remaining masters are round-robin among themselves, and `last` is updated only by grants to masters 1..N-1.
  - Undefined: pure round-robin across all masters as described above.

## Test plan
- Reset, then all requests idle → all outputs 0, `busy=0`, `grant_id=0`.
- Master 1 reads addr 0x0200_0010, width 2; slave answers `s_ok` in the first REQ cycle with data 0xDEADBEEF → `s_read` high for 1 cycle; `m_ok=3'b010` with `m_rdata=0xDEADBEEF` exactly 2 cycles after the request edge.
- All 3 masters requesting continuously, re-asserting after each ok, with a 1-cycle slave → grant order 0,1,2,0,1,2; each `m_ok` 3 cycles apart; without the macro no master is starved.
- With `ARB_FIXED_PRIO_EN`, masters 0 and 2 requesting continuously → master 0 wins every transaction. With master 0 idle, masters 1 and 2 alternate.
- Master 2 writes 0x55 at width 0 with `m_read` and `m_write` both high; slave delays `s_ok` 5 cycles → `s_write=1` and `s_read=0` for 5 cycles; `m_rdata` unchanged; `m_ok=3'b100` once.
- `rst` asserted in the 2nd REQ cycle of a stalled read → next cycle strobes are 0, no `m_ok` pulse, and master 0 is granted first after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-master round-robin arbiter in front of a single memory slave port.
// Each master uses the mem_read/mem_write/ok handshake. One winner is picked per
// transaction, its request fields are registered onto the slave port, and the
// completion pulse is returned only to that master.
//
// Optional build macro:
//   ARB_FIXED_PRIO_EN - master 0 always wins when requesting; the others share
//                       round-robin and only their grants move the pointer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_addr/m_wdata      packed per-master address / write data (master i at [i*W +: W])
//   m_width             packed per-master access width (0 byte, 1 half, 2 word)
//   m_read/m_write      per-master request strobes (both high = write)
//   m_rdata             read data, valid while the master's m_ok bit is high
//   m_ok                one-hot single-cycle completion pulse
//   s_addr/s_wdata/s_width/s_read/s_write   registered slave request
//   s_rdata/s_ok        slave response
//   grant_id            current or last granted master
//   busy                transaction in progress (REQ or RESP)
module mem_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned GID_W       = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]      m_width,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_ok,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [1:0]                    s_width,
  output logic                          s_read,
  output logic                          s_write,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ok,
  output logic [GID_W-1:0]              grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  state_e                   state_q, state_d;
  logic [GID_W-1:0]         last_q, last_d;
  logic [GID_W-1:0]         grant_q, grant_d;
  logic [NUM_MASTERS-1:0]   m_ok_q, m_ok_d;
  logic [DATA_W-1:0]        m_rdata_q, m_rdata_d;
  logic [ADDR_W-1:0]        s_addr_q, s_addr_d;
  logic [DATA_W-1:0]        s_wdata_q, s_wdata_d;
  logic [1:0]               s_width_q, s_width_d;
  logic                     s_read_q, s_read_d;
  logic                     s_write_q, s_write_d;
  logic                     busy_q, busy_d;

  logic [ADDR_W-1:0]        addr_a  [NUM_MASTERS];
  logic [DATA_W-1:0]        wdata_a [NUM_MASTERS];
  logic [1:0]               width_a [NUM_MASTERS];

  logic [NUM_MASTERS-1:0]   req;
  logic [NUM_MASTERS-1:0]   rr_req;
  logic                     win_found;
  logic [GID_W-1:0]         win_id;
  logic                     upd_last;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      addr_a[i]  = m_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = m_wdata[i*DATA_W +: DATA_W];
      width_a[i] = m_width[i*2 +: 2];
    end
  end

  // Winner selection: scan from last+1 with wrap, first requester wins.
  always_comb begin
    int unsigned      idx;
    logic [GID_W-1:0] cand;
    req       = m_read | m_write;
    rr_req    = req;
`ifdef ARB_FIXED_PRIO_EN
    rr_req[0] = 1'b0;
`endif
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      cand = GID_W'(idx);
      if (!win_found && rr_req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    upd_last = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
    // Master 0 overrides the rotation and leaves the pointer untouched.
    if (req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
      upd_last  = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    m_ok_d    = '0;
    m_rdata_d = m_rdata_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_width_d = s_width_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    busy_d    = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          s_addr_d  = addr_a[win_id];
          s_wdata_d = wdata_a[win_id];
          s_width_d = width_a[win_id];
          s_write_d = m_write[win_id];
          s_read_d  = ~m_write[win_id];
          grant_d   = win_id;
          if (upd_last) last_d = win_id;
          busy_d    = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_ok) begin
          if (s_read_q) m_rdata_d = s_rdata;
          s_read_d        = 1'b0;
          s_write_d       = 1'b0;
          m_ok_d[grant_q] = 1'b1;
          state_d         = ST_RESP;
        end
      end
      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= GID_W'(NUM_MASTERS - 1);
      grant_q   <= '0;
      m_ok_q    <= '0;
      m_rdata_q <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_width_q <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      m_ok_q    <= m_ok_d;
      m_rdata_q <= m_rdata_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_width_q <= s_width_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
      busy_q    <= busy_d;
    end
  end

  assign m_ok     = m_ok_q;
  assign m_rdata  = m_rdata_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_width  = s_width_q;
  assign s_read   = s_read_q;
  assign s_write  = s_write_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with 3 masters.
module tb_mem_arbiter;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wdata = '0;
  logic [NM*2-1:0]  m_width = '0;
  logic [NM-1:0]    m_read = '0;
  logic [NM-1:0]    m_write = '0;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ok;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [1:0]       s_width;
  logic             s_read;
  logic             s_write;
  logic [DW-1:0]    s_rdata = '0;
  logic             s_ok = 1'b0;
  logic [1:0]       grant_id;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_arbiter #(
    .NUM_MASTERS(NM),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width),
    .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .m_ok(m_ok),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width),
    .s_read(s_read), .s_write(s_write),
    .s_rdata(s_rdata), .s_ok(s_ok),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_read  = '0;
    m_write = '0;
    s_ok    = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // n back-to-back transactions with a slave answering in the first REQ cycle.
  // order holds the expected winner of transaction t in bits [2t +: 2].
  task automatic run_rr(input logic [NM-1:0] reqs, input int unsigned n, input logic [15:0] order);
    logic [1:0] e;
    for (int unsigned i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h100;
      m_width[i*2 +: 2]  = 2'd2;
    end
    m_read = reqs;
    s_ok   = 1'b1;
    for (int unsigned t = 0; t < n; t++) begin
      e       = order[2*t +: 2];
      s_rdata = 32'hA000_0000 | 32'(t);
      tick();
      check("rr_grant", 32'(grant_id), 32'(e));
      check("rr_saddr", s_addr, 32'h1000_0000 + 32'(e) * 32'h100);
      check("rr_sread", 32'(s_read), 32'd1);
      tick();
      check("rr_ok", 32'(m_ok), 32'(3'b001 << e));
      check("rr_rdata", m_rdata, 32'hA000_0000 | 32'(t));
      if (t == n - 1) begin
        m_read = '0;
        s_ok   = 1'b0;
      end
      tick();
      check("rr_ok_clr", 32'(m_ok), 32'd0);
    end
    check("rr_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_mok", 32'(m_ok), 32'd0);
    check("rst_rdata", m_rdata, 32'd0);
    check("rst_strobes", {30'd0, s_read, s_write}, 32'd0);
    check("rst_saddr", s_addr, 32'd0);
    check("rst_swdata", s_wdata, 32'd0);
    check("rst_swidth", 32'(s_width), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Master 1 single read, slave answers in first REQ cycle
    m_addr[1*AW +: AW] = 32'h0200_0010;
    m_width[1*2 +: 2]  = 2'd2;
    m_read             = 3'b010;
    tick();
    check("rd_sread", 32'(s_read), 32'd1);
    check("rd_swrite", 32'(s_write), 32'd0);
    check("rd_saddr", s_addr, 32'h0200_0010);
    check("rd_swidth", 32'(s_width), 32'd2);
    check("rd_gid", 32'(grant_id), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_mok0", 32'(m_ok), 32'd0);
    m_read  = '0;
    s_ok    = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    tick();
    check("rd_sread_drop", 32'(s_read), 32'd0);
    check("rd_mok", 32'(m_ok), 32'b010);
    check("rd_rdata", m_rdata, 32'hDEAD_BEEF);
    s_ok = 1'b0;
    tick();
    check("rd_mok_clr", 32'(m_ok), 32'd0);
    check("rd_busy_clr", 32'(busy), 32'd0);
    check("rd_gid_hold", 32'(grant_id), 32'd1);

    // All three masters continuously: 0,1,2,0,1,2
    do_reset();
    run_rr(3'b111, 6, 16'h0924);

    // Master 2 write (read+write both high), slave stalls 5 cycles
    m_addr[2*AW +: AW]  = 32'h0000_0040;
    m_wdata[2*DW +: DW] = 32'h0000_0055;
    m_width[2*2 +: 2]   = 2'd0;
    m_read              = 3'b100;
    m_write             = 3'b100;
    s_rdata             = 32'h1234_5678;
    tick();
    for (int unsigned c = 0; c < 5; c++) begin
      check("wr_swrite", 32'(s_write), 32'd1);
      check("wr_sread", 32'(s_read), 32'd0);
      check("wr_mok0", 32'(m_ok), 32'd0);
      if (c == 0) begin
        check("wr_swdata", s_wdata, 32'h55);
        check("wr_swidth", 32'(s_width), 32'd0);
        check("wr_gid", 32'(grant_id), 32'd2);
      end
      if (c == 4) s_ok = 1'b1;
      tick();
    end
    check("wr_mok", 32'(m_ok), 32'b100);
    check("wr_rdata_keep", m_rdata, 32'hA000_0005);
    check("wr_swrite_drop", 32'(s_write), 32'd0);
    m_read  = '0;
    m_write = '0;
    s_ok    = 1'b0;
    tick();
    check("wr_mok_clr", 32'(m_ok), 32'd0);

    // Reset during the 2nd REQ cycle of a stalled read
    m_addr[1*AW +: AW] = 32'h3000_0000;
    m_width[1*2 +: 2]  = 2'd1;
    m_read             = 3'b010;
    tick();
    check("ab_sread1", 32'(s_read), 32'd1);
    check("ab_gid", 32'(grant_id), 32'd1);
    tick();
    check("ab_sread2", 32'(s_read), 32'd1);
    rst                = 1'b1;
    s_ok               = 1'b1;
    m_addr[0*AW +: AW] = 32'h0000_0A00;
    m_addr[2*AW +: AW] = 32'h0000_0C00;
    m_read             = 3'b101;
    tick();
    check("ab_strobes", {30'd0, s_read, s_write}, 32'd0);
    check("ab_mok", 32'(m_ok), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_gid_rst", 32'(grant_id), 32'd0);
    check("ab_saddr", s_addr, 32'd0);
    tick();
    check("ab_mok_hold", 32'(m_ok), 32'd0);
    rst = 1'b0;
    tick();
    check("ab_first_gid", 32'(grant_id), 32'd0);
    check("ab_first_addr", s_addr, 32'h0000_0A00);
    tick();
    check("ab_first_ok", 32'(m_ok), 32'b001);
    m_read = '0;
    s_ok   = 1'b0;
    tick();

    // Masters 0 and 2 continuously, then 1 and 2
    do_reset();
`ifdef ARB_FIXED_PRIO_EN
    run_rr(3'b101, 4, 16'h0000);
`else
    run_rr(3'b101, 4, 16'h0088);
`endif
    run_rr(3'b110, 4, 16'h0099);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
